// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    localparam int STREAK_W = 3;
    localparam int WDOG_W   = 8;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, data and downstream memory signals of the arbiter.
interface mem_arb_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_w_en;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_strobe;
    logic [31:0] m_addr;
    logic [3:0]  m_w_en;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_req, d_addr, d_w_en, d_wdata,
        output d_ready, d_rdata, d_err,
        output m_strobe, m_addr, m_w_en, m_wdata,
        input  m_ready, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_req, d_addr, d_w_en, d_wdata,
        input  d_ready, d_rdata, d_err,
        input  m_strobe, m_addr, m_w_en, m_wdata,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter; flags the cycle in which TIMEOUT busy cycles elapse.
import mem_arb_pkg::*;

module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam bit ON = (TIMEOUT != 0);
    localparam logic [WDOG_W-1:0] LAST =
        ON ? WDOG_W'(TIMEOUT - 1) : '0;

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && ON)
            cnt <= cnt + 1'b1;
    end

    // flag fires on the TIMEOUT-th busy cycle itself
    assign timeout = ON && en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one memory port with
// a D-streak starvation guard and a hang watchdog.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus,
    output logic      busy
);

    localparam logic [STREAK_W-1:0] STREAK_MAX =
        STREAK_W'(MAX_D_STREAK);

    arb_state_t state, state_nx;
    arb_src_t   src;

    logic [STREAK_W-1:0] streak;
    logic        grant_i, grant_d;
    logic        busy_st, wd_to, m_done, m_fail;
    logic [31:0] rsp_data;

    logic [31:0] m_addr_q, m_wdata_q;
    logic [3:0]  m_w_en_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        i_err_q, d_err_q;

    assign busy_st = (state == BUSY_I) || (state == BUSY_D);
    assign m_done  = busy_st && bus.m_ready;
    assign m_fail  = busy_st && !bus.m_ready && wd_to;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (bus.d_req &&
                !(bus.i_req && streak == STREAK_MAX))
                grant_d = 1'b1;
            else if (bus.i_req)
                grant_i = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_d)
                    state_nx = BUSY_D;
                else if (grant_i)
                    state_nx = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (m_done || m_fail)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // stores and timeouts return zero data
    always_comb begin
        rsp_data = bus.m_rdata;
        if (m_fail || m_w_en_q != '0)
            rsp_data = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src       <= SRC_I;
            streak    <= '0;
            m_addr_q  <= '0;
            m_w_en_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else begin
            if (grant_d) begin
                src       <= SRC_D;
                m_addr_q  <= bus.d_addr;
                m_w_en_q  <= bus.d_w_en;
                m_wdata_q <= bus.d_wdata;
                if (!bus.i_req)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end else if (grant_i) begin
                src       <= SRC_I;
                m_addr_q  <= bus.i_addr;
                m_w_en_q  <= '0;
                m_wdata_q <= '0;
                streak    <= '0;
            end
            if (m_done || m_fail) begin
                if (src == SRC_D) begin
                    d_rdata_q <= rsp_data;
                    d_err_q   <= m_fail;
                end else begin
                    i_rdata_q <= rsp_data;
                    i_err_q   <= m_fail;
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign bus.m_strobe = busy_st;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_w_en   = m_w_en_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.i_ready  = (state == RESP) && (src == SRC_I);
    assign bus.d_ready  = (state == RESP) && (src == SRC_D);
    assign bus.i_rdata  = i_rdata_q;
    assign bus.i_err    = i_err_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!busy_st),
        .en     (busy_st),
        .timeout(wd_to)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT=10).
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;
    logic both_seen;
    logic saw_rdy;
    logic is_i;
    logic [31:0] ia;

    mem_arb_if bus ();

    mem_port_arbiter #(
        .MAX_D_STREAK(4),
        .TIMEOUT     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.i_ready && bus.d_ready)
            both_seen = 1'b1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        both_seen = 1'b0;
        rst       = 1'b0;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_addr = '0;
        bus.d_w_en = '0;
        bus.d_wdata = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;

        step();
        chk("rst_strobe", 32'(bus.m_strobe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_iready", 32'(bus.i_ready), 0);
        chk("rst_dready", 32'(bus.d_ready), 0);
        chk("rst_maddr", bus.m_addr, 0);
        rst = 1'b1;
        step();

        // I-only fetch
        bus.i_req = 1'b1;
        bus.i_addr = 32'h100;
        step();
        chk("i_strobe", 32'(bus.m_strobe), 1);
        chk("i_maddr", bus.m_addr, 32'h100);
        chk("i_mwen", 32'(bus.m_w_en), 0);
        chk("i_busy", 32'(busy), 1);
        step();
        chk("i_hold", bus.m_addr, 32'h100);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h93;
        step();
        chk("i_ready", 32'(bus.i_ready), 1);
        chk("i_rdata", bus.i_rdata, 32'h93);
        chk("i_err", 32'(bus.i_err), 0);
        chk("i_dready", 32'(bus.d_ready), 0);
        chk("i_strobe_resp", 32'(bus.m_strobe), 0);
        bus.m_ready = 1'b0;
        bus.i_req = 1'b0;
        step();
        chk("i_ready_drop", 32'(bus.i_ready), 0);
        chk("i_idle", 32'(busy), 0);

        // simultaneous: D first, then I
        bus.i_req = 1'b1;
        bus.i_addr = 32'h300;
        bus.d_req = 1'b1;
        bus.d_addr = 32'h2000;
        bus.d_w_en = 4'hF;
        bus.d_wdata = 32'hDEADBEEF;
        step();
        chk("s_maddr", bus.m_addr, 32'h2000);
        chk("s_mwdata", bus.m_wdata, 32'hDEADBEEF);
        chk("s_mwen", 32'(bus.m_w_en), 32'hF);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h12345678;
        step();
        chk("s_dready", 32'(bus.d_ready), 1);
        chk("s_drdata", bus.d_rdata, 0);
        chk("s_derr", 32'(bus.d_err), 0);
        chk("s_iready", 32'(bus.i_ready), 0);
        bus.m_ready = 1'b0;
        bus.d_req = 1'b0;
        bus.d_w_en = '0;
        step();
        step();
        chk("s_i_maddr", bus.m_addr, 32'h300);
        chk("s_i_mwen", 32'(bus.m_w_en), 0);
        chk("s_i_mwdata", bus.m_wdata, 0);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hA5;
        step();
        chk("s_i_ready", 32'(bus.i_ready), 1);
        chk("s_i_rdata", bus.i_rdata, 32'hA5);
        bus.m_ready = 1'b0;
        bus.i_req = 1'b0;
        step();

        // starvation guard: D D D D I D D D D I
        ia = 32'h400;
        bus.i_req = 1'b1;
        bus.i_addr = ia;
        bus.d_req = 1'b1;
        bus.d_addr = 32'h3000;
        bus.d_w_en = '0;
        for (int n = 0; n < 10; n++) begin
            is_i = (n == 4) || (n == 9);
            step();
            chk("stv_addr", bus.m_addr, is_i ? ia : 32'h3000);
            bus.m_ready = 1'b1;
            bus.m_rdata = 32'(n + 1);
            step();
            chk("stv_rdy",
                32'(is_i ? bus.i_ready : bus.d_ready), 1);
            chk("stv_other",
                32'(is_i ? bus.d_ready : bus.i_ready), 0);
            chk("stv_data",
                is_i ? bus.i_rdata : bus.d_rdata, 32'(n + 1));
            bus.m_ready = 1'b0;
            if (is_i) begin
                ia = ia + 32'd4;
                bus.i_addr = ia;
            end
            step();
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();

        // watchdog timeout after 10 busy cycles
        bus.d_req = 1'b1;
        bus.d_addr = 32'h5000;
        step();
        chk("wd_strobe1", 32'(bus.m_strobe), 1);
        for (int k = 0; k < 9; k++)
            step();
        chk("wd_strobe10", 32'(bus.m_strobe), 1);
        step();
        chk("wd_strobe_drop", 32'(bus.m_strobe), 0);
        chk("wd_dready", 32'(bus.d_ready), 1);
        chk("wd_derr", 32'(bus.d_err), 1);
        chk("wd_drdata", bus.d_rdata, 0);
        bus.d_req = 1'b0;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h77;
        step();
        step();
        chk("wd_late_busy", 32'(busy), 0);
        chk("wd_late_dready", 32'(bus.d_ready), 0);
        chk("wd_late_drdata", bus.d_rdata, 0);
        bus.m_ready = 1'b0;
        step();

        // m_ready on the exact timeout cycle wins
        bus.d_req = 1'b1;
        bus.d_addr = 32'h6000;
        step();
        for (int k = 0; k < 9; k++)
            step();
        chk("tie_strobe", 32'(bus.m_strobe), 1);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h55;
        step();
        chk("tie_dready", 32'(bus.d_ready), 1);
        chk("tie_derr", 32'(bus.d_err), 0);
        chk("tie_drdata", bus.d_rdata, 32'h55);
        bus.m_ready = 1'b0;
        bus.d_req = 1'b0;
        step();

        // reset while BUSY_I
        bus.i_req = 1'b1;
        bus.i_addr = 32'h700;
        step();
        chk("r_busy_pre", 32'(busy), 1);
        rst = 1'b0;
        bus.i_req = 1'b0;
        #1;
        chk("r_strobe", 32'(bus.m_strobe), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_iready", 32'(bus.i_ready), 0);
        chk("r_irdata", bus.i_rdata, 0);
        step();
        rst = 1'b1;
        saw_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.i_ready || busy)
                saw_rdy = 1'b1;
        end
        chk("r_no_ready", 32'(saw_rdy), 0);
        bus.i_req = 1'b1;
        bus.i_addr = 32'h800;
        step();
        chk("r_maddr", bus.m_addr, 32'h800);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hCAFE;
        step();
        chk("r_iready_new", 32'(bus.i_ready), 1);
        chk("r_irdata_new", bus.i_rdata, 32'hCAFE);
        bus.m_ready = 1'b0;
        bus.i_req = 1'b0;
        step();

        chk("ready_excl", 32'(both_seen), 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
